dm_rmw_ctrl: RTL and testbench

DM_RMW_CTRL -- requirements
Module: dm_rmw_ctrl

---
 rtl/dm_rmw_ctrl.sv | 154 +++++++++++++++
 tb/tb_dm_rmw_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_rmw_ctrl.sv
// Byte/half/word load-store controller over a word-wide memory; sub-word stores are done as read-modify-write.
// Latency: err 1, sw 2, load 2+RD_LATENCY, sub-word store 3+RD_LATENCY cycles; req_ready only in IDLE (busy stalls the pipe).
module dm_rmw_ctrl #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] merged;
    logic [31:0] load_val;

    assign req_bad = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = S_RESP;
                    else if (req_we && req_size == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Count reaches zero in the cycle mem_rdata is valid.
                if (cnt_q == 2'd0) begin
                    rdata_d = mem_rdata;
                    state_d = we_q ? S_WRITE : S_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        lane_byte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        merged    = rdata_q;
        load_val  = rdata_q;
        case (size_q)
            2'b00: begin
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                load_val = {{24{sgn_q & lane_byte[7]}}, lane_byte};
            end
            2'b01: begin
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                load_val = {{16{sgn_q & lane_half[15]}}, lane_half};
            end
            default: merged = wdata_q;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign mem_rd_en  = (state_q == S_READ);
    assign mem_we     = (state_q == S_WRITE);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = mem_we ? merged : 32'h0;
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_val : 32'h0;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Randomized bench for dm_rmw_ctrl: word memory model plus a per-request reference of data and timing.
module tb_dm_rmw_ctrl;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_wdata;
    logic        mem_rd_en, mem_we;

    dm_rmw_ctrl #(.RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit [31:0] mem [bit [29:0]];
    int        due_cyc[$];
    bit [31:0] due_dat[$];

    int        rd_cnt = 0, we_cnt = 0, resp_cnt = 0;
    int        last_rd_cyc, last_we_cyc, last_resp_cyc = 0;
    bit [31:0] last_rd_addr, last_we_addr, last_we_dat, last_resp_dat;
    bit        last_resp_err;
    bit        prev_held = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] mem_get(input bit [29:0] idx);
        return mem.exists(idx) ? mem[idx] : 32'h0;
    endfunction

    // One cycle: observe the DUT mid-cycle and play the memory side.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (due_cyc.size() > 0 && due_cyc[0] == cyc) begin
            mem_rdata = due_dat.pop_front();
            void'(due_cyc.pop_front());
        end else begin
            mem_rdata = $urandom();
        end
        chk("rd_we_excl", {31'b0, mem_rd_en & mem_we}, 32'h0);
        if (!resp_valid) chk("quiet_resp", resp_rdata | {31'b0, resp_err}, 32'h0);
        if (mem_rd_en) begin
            rd_cnt++;
            last_rd_cyc  = cyc;
            last_rd_addr = mem_addr;
            due_cyc.push_back(cyc + LAT);
            due_dat.push_back(mem_get(mem_addr[31:2]));
        end
        if (mem_we) begin
            we_cnt++;
            last_we_cyc  = cyc;
            last_we_addr = mem_addr;
            last_we_dat  = mem_wdata;
            mem[mem_addr[31:2]] = mem_wdata;
        end
        if (resp_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            last_resp_dat = resp_rdata;
            last_resp_err = resp_err;
        end
    endtask

    task automatic garbage(input bit vld);
        req_valid  = vld;
        req_we     = 1'($urandom());
        req_size   = 2'($urandom());
        req_signed = 1'($urandom());
        req_addr   = $urandom();
        req_wdata  = $urandom();
    endtask

    task automatic do_req(input bit we, input bit [1:0] size, input bit sgn,
                          input bit [31:0] addr, input bit [31:0] wdata,
                          input bit hold, input string nm);
        bit        err, acc;
        bit [31:0] word, v, mask, exp_wd, exp_rd;
        int        sh, e_resp, e_rd, e_we, t, rd0, we0, resp0, busy_bad, gap_ref;
        word = mem_get(addr[31:2]);
        err  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        v = word; mask = 32'hFFFF_FFFF; sh = 0;
        if (size == 2'd0) begin
            sh = 8 * addr[1:0];
            v = (word >> sh) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            mask = 32'hFF << sh;
        end else if (size == 2'd1) begin
            sh = 16 * addr[1];
            v = (word >> sh) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
            mask = 32'hFFFF << sh;
        end
        exp_wd = (word & ~mask) | ((wdata << sh) & mask);
        exp_rd = (we || err) ? 32'h0 : v;
        if (err) begin
            e_resp = 1; e_rd = -1; e_we = -1;
        end else if (we && size == 2'd2) begin
            e_resp = 2; e_rd = -1; e_we = 1;
        end else if (we) begin
            e_resp = 3 + LAT; e_rd = 1; e_we = 2 + LAT;
        end else begin
            e_resp = 2 + LAT; e_rd = 1; e_we = -1;
        end
        rd0 = rd_cnt; we0 = we_cnt; resp0 = resp_cnt; gap_ref = last_resp_cyc;
        acc = 0; t = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            tick();
            req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
            req_addr = addr; req_wdata = wdata;
            if (req_ready) begin acc = 1; t = cyc; end
        end
        chk({nm, "_accept"}, {31'b0, acc}, 32'h1);
        if (!acc) begin
            req_valid = 0;
            return;
        end
        if (prev_held) chk({nm, "_b2b_gap"}, t - gap_ref, 32'd1);
        busy_bad = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            garbage(hold);
            if (!busy || req_ready) busy_bad++;
            if (resp_cnt != resp0) break;
        end
        if (!hold) req_valid = 0;
        prev_held = hold;
        chk({nm, "_busy"}, busy_bad, 32'd0);
        chk({nm, "_resp_n"}, resp_cnt - resp0, 32'd1);
        chk({nm, "_resp_t"}, last_resp_cyc - t, e_resp);
        chk({nm, "_err"}, {31'b0, last_resp_err}, {31'b0, err});
        chk({nm, "_rdata"}, last_resp_dat, exp_rd);
        chk({nm, "_rd_n"}, rd_cnt - rd0, (e_rd >= 0) ? 32'd1 : 32'd0);
        chk({nm, "_we_n"}, we_cnt - we0, (e_we >= 0) ? 32'd1 : 32'd0);
        if (e_rd >= 0 && rd_cnt != rd0) begin
            chk({nm, "_rd_t"}, last_rd_cyc - t, e_rd);
            chk({nm, "_rd_addr"}, last_rd_addr, {addr[31:2], 2'b00});
        end
        if (e_we >= 0 && we_cnt != we0) begin
            chk({nm, "_we_t"}, last_we_cyc - t, e_we);
            chk({nm, "_we_addr"}, last_we_addr, {addr[31:2], 2'b00});
            chk({nm, "_we_dat"}, last_we_dat, exp_wd);
        end
    endtask

    task automatic reset_in_wait();
        int we0, resp0;
        bit acc;
        mem[30'h40] = 32'hAABB_CCDD;
        we0 = we_cnt; resp0 = resp_cnt; acc = 0;
        tick();
        req_valid = 1; req_we = 1; req_size = 2'd0; req_signed = 0;
        req_addr = 32'h102; req_wdata = 32'h11;
        acc = req_ready;
        chk("rst_accept", {31'b0, acc}, 32'h1);
        tick();
        req_valid = 0;
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'h1);
        tick();
        chk("rst_busy_wait", {31'b0, busy}, 32'h1);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        for (int k = 0; k < 6; k++) tick();
        chk("rst_no_we", we_cnt - we0, 32'd0);
        chk("rst_no_resp", resp_cnt - resp0, 32'd0);
        prev_held = 0;
    endtask

    initial begin
        rst = 1; mem_rdata = 32'h0;
        req_valid = 0; req_we = 0; req_size = 2'd0; req_signed = 0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) mem[30'h40 + 30'(i)] = $urandom();
        tick(); tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_busy0", {31'b0, busy}, 32'h0);
        chk("rst_outs", {29'b0, resp_valid, mem_rd_en, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst = 0;

        mem[30'h40] = 32'hAABB_CCDD;
        do_req(1, 2'd0, 0, 32'h102, 32'h11, 0, "sb");
        chk("sb_mem", mem_get(30'h40), 32'hAA11_CCDD);
        mem[30'h40] = 32'hAABB_CCDD;
        do_req(1, 2'd1, 0, 32'h102, 32'h5566, 0, "sh");
        chk("sh_mem", mem_get(30'h40), 32'h5566_CCDD);
        mem[30'h40] = 32'hAABB_CCDD;
        do_req(1, 2'd2, 0, 32'h104, 32'h1234_5678, 0, "sw");
        do_req(0, 2'd0, 1, 32'h103, 32'h0, 0, "lb_s");
        do_req(0, 2'd0, 0, 32'h103, 32'h0, 0, "lb_u");
        do_req(0, 2'd1, 1, 32'h100, 32'h0, 0, "lh_s");
        do_req(0, 2'd2, 0, 32'h104, 32'h0, 0, "lw");
        do_req(1, 2'd1, 0, 32'h101, 32'hFFFF, 0, "sh_mis");
        do_req(0, 2'd3, 0, 32'h100, 32'h0, 0, "size3");
        do_req(1, 2'd0, 0, 32'h101, 32'h77, 1, "held1");
        do_req(0, 2'd1, 0, 32'h102, 32'h0, 0, "held2");
        reset_in_wait();

        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = prev_held ? 0 : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                garbage(0);
            end
            do_req(1'($urandom()), 2'($urandom()), 1'($urandom()),
                   32'h100 + 32'($urandom_range(0, 63)), $urandom(),
                   ($urandom_range(0, 3) == 0), "rnd");
        end
        req_valid = 0;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
